my_rr_mux: RTL
==============

Name: my_rr_mux

Overview:
Parametrised, registered successor to the 8-way 16-bit mux. Selects one of CHANNELS W-bit input streams and forwards it through a single output register stage with valid/ready handshaking. The block has two modes. In fixed mode it follows `sel`. In round-robin mode it arbitrates fairly among the valid inputs. It sits between multiple producers (e.g. register-file read ports, I/O sources) and a single consumer on the datapath.

Parameters:
- WIDTH, 16, data word width in bits.
- CHANNELS, 8, number of input channels (>= 2; need not be a power of 2).
- SEL_W, $clog2(CHANNELS), width of `sel` and `out_chan`. Derived; not to be overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_data  input  CHANNELS*WIDTH  packed input words; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready (combinational); at most one bit high.
- mode  input  1  0 = fixed select via `sel`, 1 = round-robin.
- sel  input  SEL_W  channel index used in fixed mode.
- out_data  output  WIDTH  registered selected word.
- out_chan  output  SEL_W  registered index of the channel that supplied `out_data`.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts the word.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - out_valid<=0, out_data<=0, out_chan<=0.
  - Round-robin pointer ptr<=0.
  - in_ready forced to all-zero while rst_n=0.
  - Reset mid-operation discards any held output word; no input is accepted that cycle.
- Load condition: `load = !out_valid || out_ready`.
- Grant g is combinational:
  - mode=0: g=sel if sel<CHANNELS and in_valid[sel]=1. Otherwise there is no grant; this includes sel>=CHANNELS.
  - mode=1: g is the first i with in_valid[i]=1, scanning ptr, ptr+1, …, CHANNELS-1, 0, …, ptr-1. No grant if in_valid is all-zero.
- in_ready[g] = load && rst_n. All other in_ready bits are 0. A transfer on channel g occurs when in_valid[g] && in_ready[g].
- On a rising edge with rst_n=1 and load=1:
  - If there is a grant: out_valid<=1, out_data<=in_data[g], out_chan<=g.
    - If mode=1, also ptr<=(g+1) mod CHANNELS, wrapping from CHANNELS-1 to 0.
  - If there is no grant: out_valid<=0. out_data and out_chan hold their values.
- On a rising edge with load=0 (out_valid=1, out_ready=0): out_data, out_chan, out_valid and ptr hold. This is backpressure; no input is accepted.
- Latency and throughput:
  - Latency is 1 cycle from input transfer to out_valid.
  - Sustained throughput is 1 word per cycle when out_ready=1.
  - A simultaneous output drain and input accept in the same cycle is required.
- ptr only changes on a round-robin transfer.
  - In fixed mode ptr is preserved.
  - Switching `mode` or `sel` affects only the next grant. It never alters a word already held.
- An input that lowers in_valid without being granted is not captured. Producers must hold in_data stable while in_valid=1 and not granted.
- No combinational path exists from in_data to out_data. A path from out_ready to in_ready is allowed.

Test Plan:
- Reset: assert rst_n=0 for 2 cycles with in_valid=8'hFF and out_ready=1 -> in_ready=0 and out_valid=0; after release, first grant goes to channel 0 (mode=1).
- Fixed mode: mode=0, sel=5, in_valid=8'hFF, in_data[5]=16'hBEEF, out_ready=1.
  - Expect in_ready=8'b0010_0000, and next cycle out_valid=1, out_data=16'hBEEF, out_chan=5.
  - Then sel=5 with in_valid[5]=0 -> out_valid drops to 0 next cycle.
- Round-robin fairness: mode=1, in_valid=8'hFF held for 10 cycles, out_ready=1, in_data[i]=16'h1000+i -> out_chan sequence 0,1,2,3,4,5,6,7,0,1 (wrap-around), one word per cycle.
- Sparse round-robin: mode=1, in_valid=8'b1000_0101 held, out_ready=1 -> out_chan sequence 0,2,7,0,2,7.
- Backpressure: while out_valid=1 with out_chan=3, hold out_ready=0 for 4 cycles.
  - Expect out_data and out_chan stable, in_ready=0, and ptr unchanged.
  - Raise out_ready -> the same cycle grants next channel 4 (if valid) with no bubble.
- Non-power-of-2 width: CHANNELS=5, WIDTH=8, mode=0, sel=6 -> in_ready=0 and out_valid stays 0. Mode=1, in_valid=5'b10001 -> out_chan 0,4,0,4.

Source files
------------

// File: rtl/my_rr_mux_if.sv
// my_rr_mux_if: bundles the input-side and output-side handshake signals of
// my_rr_mux.
//   in_data   CHANNELS*WIDTH  packed input words, channel i at [i*WIDTH +: WIDTH]
//   in_valid  CHANNELS        per-channel valid
//   in_ready  CHANNELS        per-channel ready, at most one bit high
//   mode      1               0 = fixed select via sel, 1 = round-robin
//   sel       SEL_W           channel index used in fixed mode
//   out_data  WIDTH           registered selected word
//   out_chan  SEL_W           registered index of the supplying channel
//   out_valid 1               output register holds a word
//   out_ready 1               consumer accepts the word
// Modports: master drives the producers/consumer side, slave is the mux.
interface my_rr_mux_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 8
);
  localparam int SEL_W = $clog2(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/my_rr_mux.sv
// my_rr_mux: selects one of CHANNELS WIDTH-bit valid/ready input streams and
// forwards it through a single output register stage.
//   clk    system clock, all state updates on the rising edge
//   rst_n  synchronous active-low reset
//   bus    my_rr_mux_if.slave: in_data/in_valid/in_ready, mode, sel,
//          out_data/out_chan/out_valid/out_ready
// mode=0 follows sel (no grant when sel is out of range or not valid);
// mode=1 round-robins over valid channels starting at ptr.
module my_rr_mux #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 8
) (
  input logic        clk,
  input logic        rst_n,
  my_rr_mux_if.slave bus
);
  localparam int SEL_W = $clog2(CHANNELS);
  localparam logic [SEL_W:0]   CHANNELS_W = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_CHAN  = SEL_W'(CHANNELS - 1);

  logic [WIDTH-1:0] word [CHANNELS];

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_unpack
      assign word[gi] = bus.in_data[gi*WIDTH +: WIDTH];
    end
  endgenerate

  logic                out_valid_reg;
  logic [WIDTH-1:0]    out_data_reg;
  logic [SEL_W-1:0]    out_chan_reg;
  logic [SEL_W-1:0]    ptr_reg;
  logic [SEL_W-1:0]    ptr_next;

  logic                load;
  logic                grant_valid;
  logic [SEL_W-1:0]    grant;
  logic [SEL_W:0]      idx;
  logic [CHANNELS-1:0] in_ready;

  // The output register can take a new word when empty or being drained.
  assign load = !out_valid_reg || bus.out_ready;

  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    idx         = '0;
    if (!bus.mode) begin
      if ({1'b0, bus.sel} < CHANNELS_W) begin
        if (bus.in_valid[bus.sel]) begin
          grant_valid = 1'b1;
          grant       = bus.sel;
        end
      end
    end else begin
      // Scan from the farthest position back towards ptr so the last hit,
      // which wins, is the first valid channel at or after ptr.
      // idx is one bit wider so ptr+k cannot overflow before the wrap.
      for (int k = CHANNELS - 1; k >= 0; k--) begin
        idx = {1'b0, ptr_reg} + (SEL_W+1)'(k);
        if (idx >= CHANNELS_W) begin
          idx = idx - CHANNELS_W;
        end
        if (bus.in_valid[idx]) begin
          grant_valid = 1'b1;
          grant       = idx[SEL_W-1:0];
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (rst_n && load && grant_valid) begin
      in_ready[grant] = 1'b1;
    end
  end

  assign ptr_next = (grant == LAST_CHAN) ? '0 : grant + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_chan_reg  <= '0;
      ptr_reg       <= '0;
    end else if (load) begin
      if (grant_valid) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= word[grant];
        out_chan_reg  <= grant;
        if (bus.mode) begin
          ptr_reg <= ptr_next;
        end
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_chan  = out_chan_reg;
endmodule
